store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with load hazard detection
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge stores into the newest entry.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [3:0]  be_in,
   input  logic        load_req,
   input  logic [31:0] load_addr,
   output logic        load_hazard,
   output logic        full,
   output logic        empty,
   output logic [4:0]  count,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready
);
   localparam int PW = $clog2(DEPTH);

   logic [29:0]   addr_q [DEPTH];
   logic [29:0]   addr_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [3:0]    be_q   [DEPTH];
   logic [3:0]    be_d   [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [4:0]    count_q, count_d;

   logic          store_ok;
   logic          push;
   logic          pop;
   logic          merge;
   logic [PW-1:0] offset [DEPTH];
   logic [DEPTH-1:0] match;
   logic          unused_addr_lsbs;

   assign unused_addr_lsbs = ^{addr_in[1:0], load_addr[1:0]};

   assign count     = count_q;
   assign empty     = (count_q == 5'd0);
   assign full      = (count_q == 5'(DEPTH));
   assign mem_we    = !empty;
   assign mem_addr  = {addr_q[head_q], 2'b00};
   assign mem_wdata = data_q[head_q];
   assign mem_be    = be_q[head_q];

   assign pop      = mem_we && mem_ready;
   assign store_ok = we_in && (be_in != 4'b0000);

`ifdef STORE_BUFFER_COALESCE_EN
   logic [PW-1:0] last_idx;
   assign last_idx = tail_q - PW'(1);
   // The head being drained this edge is already on the bus, so it cannot absorb new bytes.
   assign merge = store_ok && !empty && (addr_q[last_idx] == addr_in[31:2])
                  && !(pop && (last_idx == head_q));
`else
   assign merge = 1'b0;
`endif

   assign push = store_ok && !merge && !full;

   // An entry is live when its distance from head is below count; this includes the head being popped.
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset[i] = PW'(i) - head_q;
         match[i]  = ({{(5-PW){1'b0}}, offset[i]} < count_q)
                     && (addr_q[i] == load_addr[31:2]);
      end
   end

   assign load_hazard = load_req && (|match);

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      be_d    = be_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         addr_d[tail_q] = addr_in[31:2];
         data_d[tail_q] = wdata_in;
         be_d[tail_q]   = be_in;
         tail_d         = tail_q + PW'(1);
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (merge) begin
         for (int b = 0; b < 4; b++) begin
            if (be_in[b]) begin
               data_d[last_idx][8*b +: 8] = wdata_in[8*b +: 8];
            end
         end
         be_d[last_idx] = be_q[last_idx] | be_in;
      end
`endif
      if (pop) begin
         head_d = head_q + PW'(1);
      end
      count_d = count_q + {4'b0, push} - {4'b0, pop};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule
